// File: rtl/ofm_pack_drain.sv
// rtl/ofm_pack_drain.sv - captures per-lane OFM bytes and drains each complete group as 32-bit LE words.
// Optional build macro OFM_PACK_RELU_EN clamps negative int8 bytes to zero at capture.
module ofm_pack_drain #(
    parameter int ACTIVE_LANES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] ofm_in,
    input  logic [15:0]  valid_in,
    output logic [31:0]  wr_data,
    output logic         wr_valid,
    input  logic         wr_ready,
    output logic         wr_last,
    output logic         busy,
    output logic         overflow
);

    if (!(ACTIVE_LANES == 4 || ACTIVE_LANES == 8 || ACTIVE_LANES == 12 || ACTIVE_LANES == 16)) begin : g_bad_lanes
        $error("ofm_pack_drain: ACTIVE_LANES must be 4, 8, 12 or 16");
    end

    localparam logic [15:0] ACT_MASK  = 16'((32'd1 << ACTIVE_LANES) - 32'd1);
    localparam logic [1:0]  LAST_WORD = 2'(ACTIVE_LANES / 4 - 1);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic [15:0]    pend_q, pend_d;
    logic [127:0]   cap_q, cap_d;
    logic [127:0]   shadow_q, shadow_d;
    logic           ovf_q, ovf_d;
    logic           group_done;
    logic           snap;

    function automatic logic [7:0] lane_byte(input logic [7:0] b);
`ifdef OFM_PACK_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    assign group_done = ((pend_q & ACT_MASK) == ACT_MASK);

    // Snapshot only from IDLE, so a last-word release always leaves one idle cycle before the next group.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pend_d   = pend_q;
        cap_d    = cap_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        snap     = (state_q == S_IDLE) && group_done;

        for (int i = 0; i < 16; i++) begin
            if (ACT_MASK[i]) begin
                if (snap) begin
                    pend_d[i] = 1'b0;
                end
                // A valid coinciding with the snapshot refills the lane; the shadow still takes the old byte.
                if (valid_in[i]) begin
                    if (snap || !pend_q[i]) begin
                        cap_d[8*i +: 8] = lane_byte(ofm_in[8*i +: 8]);
                        pend_d[i]       = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (snap) begin
                    shadow_d = cap_q;
                    wcnt_d   = 2'd0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_ready) begin
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 2'd0;
            pend_q   <= 16'd0;
            cap_q    <= 128'd0;
            shadow_q <= 128'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pend_q   <= pend_d;
            cap_q    <= cap_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_valid = (state_q == S_DRAIN);
    assign wr_data  = wr_valid ? shadow_q[{wcnt_q, 5'b0} +: 32] : 32'd0;
    assign wr_last  = wr_valid && (wcnt_q == LAST_WORD);
    assign busy     = (|(pend_q & ACT_MASK)) || wr_valid;
    assign overflow = ovf_q;

endmodule
